// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and widths for the reservation-station scheduler and its neighbours.
package rs_issue_scheduler_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int PREG_W    = 7;
  localparam int ROB_W     = 4;
  localparam int PAYLOAD_W = 44;

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_BR  = 2'b01;
  localparam logic [1:0] FU_LSU = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic                 rdy1;
    logic                 rdy2;
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [PREG_W-1:0]    prd;
    logic [ROB_W-1:0]     rob_tag;
    logic [PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// Oldest-ready picker: grants the candidate that no other candidate is older than.
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            cand,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic [$clog2(DEPTH)-1:0]    grant_idx,
  output logic                        grant_valid
);
  import rs_issue_scheduler_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] blocked;

  // age[j][c] set means j is older than c, so an older candidate blocks c
  always_comb begin
    blocked = '0;
    for (int c = 0; c < DEPTH; c++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != c) && cand[j] && age[j][c]) blocked[c] = 1'b1;
      end
    end
  end

  assign grant       = cand & ~blocked;
  assign grant_valid = |cand;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation station: buffers renamed micro-ops, wakes them on CDB broadcasts,
// and issues the oldest fully-ready one over a valid/ready handshake.
module rs_issue_scheduler #(
  parameter int DEPTH     = rs_issue_scheduler_pkg::RS_DEPTH,
  parameter int PREG_W    = rs_issue_scheduler_pkg::PREG_W,
  parameter int ROB_W     = rs_issue_scheduler_pkg::ROB_W,
  parameter int PAYLOAD_W = rs_issue_scheduler_pkg::PAYLOAD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [PREG_W-1:0]        disp_prs1,
  input  logic                     disp_prs1_rdy,
  input  logic [PREG_W-1:0]        disp_prs2,
  input  logic                     disp_prs2_rdy,
  input  logic [PREG_W-1:0]        disp_prd,
  input  logic [ROB_W-1:0]         disp_rob_tag,
  input  logic [PAYLOAD_W-1:0]     disp_payload,
  input  logic                     cdb_valid,
  input  logic [PREG_W-1:0]        cdb_preg,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [PREG_W-1:0]        issue_prs1,
  output logic [PREG_W-1:0]        issue_prs2,
  output logic [PREG_W-1:0]        issue_prd,
  output logic [ROB_W-1:0]         issue_rob_tag,
  output logic [PAYLOAD_W-1:0]     issue_payload,
  output logic [$clog2(DEPTH):0]   occupancy
);
  import rs_issue_scheduler_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            rdy1;
  logic [DEPTH-1:0]            rdy2;
  logic [DEPTH-1:0][DEPTH-1:0] age;

  logic [PREG_W-1:0]    ent_prs1    [DEPTH];
  logic [PREG_W-1:0]    ent_prs2    [DEPTH];
  logic [PREG_W-1:0]    ent_prd     [DEPTH];
  logic [ROB_W-1:0]     ent_rob_tag [DEPTH];
  logic [PAYLOAD_W-1:0] ent_payload [DEPTH];

  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] free_idx;
  logic             grant_valid;
  logic             cdb_hit;
  logic             disp_fire;
  logic             issue_fire;
  logic             byp1;
  logic             byp2;

  assign cand = valid & rdy1 & rdy2;

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .cand        (cand),
    .age         (age),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Preg 0 is the hardwired zero register and never produces a wakeup
  assign cdb_hit     = cdb_valid && (cdb_preg != '0);
  assign disp_ready  = (occupancy < CNT_W'(DEPTH)) && !flush;
  assign issue_valid = grant_valid && !flush;
  assign disp_fire   = disp_valid && disp_ready;
  assign issue_fire  = issue_valid && issue_ready;
  assign byp1        = disp_prs1_rdy || (cdb_hit && (cdb_preg == disp_prs1));
  assign byp2        = disp_prs2_rdy || (cdb_hit && (cdb_preg == disp_prs2));

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    issue_prs1    = '0;
    issue_prs2    = '0;
    issue_prd     = '0;
    issue_rob_tag = '0;
    issue_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_prs1    = ent_prs1[i];
        issue_prs2    = ent_prs2[i];
        issue_prd     = ent_prd[i];
        issue_rob_tag = ent_rob_tag[i];
        issue_payload = ent_payload[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      rdy1      <= '0;
      rdy2      <= '0;
      age       <= '0;
      occupancy <= '0;
    end else if (flush) begin
      valid     <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && cdb_hit && (ent_prs1[i] == cdb_preg)) rdy1[i] <= 1'b1;
        if (valid[i] && cdb_hit && (ent_prs2[i] == cdb_preg)) rdy2[i] <= 1'b1;
      end
      if (issue_fire) valid[grant_idx] <= 1'b0;
      // New entry is younger than every live one; its own row starts clean
      if (disp_fire) begin
        valid[free_idx] <= 1'b1;
        rdy1[free_idx]  <= byp1;
        rdy2[free_idx]  <= byp2;
        age[free_idx]   <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (valid[j]) age[j][free_idx] <= 1'b1;
        end
      end
      case ({disp_fire, issue_fire})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (disp_fire) begin
      ent_prs1[free_idx]    <= disp_prs1;
      ent_prs2[free_idx]    <= disp_prs2;
      ent_prd[free_idx]     <= disp_prd;
      ent_rob_tag[free_idx] <= disp_rob_tag;
      ent_payload[free_idx] <= disp_payload;
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed and random stimulus against an age-ordered queue model of the scheduler.
module tb_rs_issue_scheduler;
  import rs_issue_scheduler_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [PREG_W-1:0]    disp_prs1;
  logic                 disp_prs1_rdy;
  logic [PREG_W-1:0]    disp_prs2;
  logic                 disp_prs2_rdy;
  logic [PREG_W-1:0]    disp_prd;
  logic [ROB_W-1:0]     disp_rob_tag;
  logic [PAYLOAD_W-1:0] disp_payload;
  logic                 cdb_valid;
  logic [PREG_W-1:0]    cdb_preg;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [PREG_W-1:0]    issue_prs1;
  logic [PREG_W-1:0]    issue_prs2;
  logic [PREG_W-1:0]    issue_prd;
  logic [ROB_W-1:0]     issue_rob_tag;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [3:0]           occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  rs_entry_t  q[$];          // live micro-ops, oldest first
  logic [3:0] dut_issued[$]; // rob tags the DUT handed over on fire

  rs_issue_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_prs1     (disp_prs1),
    .disp_prs1_rdy (disp_prs1_rdy),
    .disp_prs2     (disp_prs2),
    .disp_prs2_rdy (disp_prs2_rdy),
    .disp_prd      (disp_prd),
    .disp_rob_tag  (disp_rob_tag),
    .disp_payload  (disp_payload),
    .cdb_valid     (cdb_valid),
    .cdb_preg      (cdb_preg),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_prs1    (issue_prs1),
    .issue_prs2    (issue_prs2),
    .issue_prd     (issue_prd),
    .issue_rob_tag (issue_rob_tag),
    .issue_payload (issue_payload),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_oldest_ready();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].rdy1 && q[i].rdy2) return i;
    end
    return -1;
  endfunction

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    cdb_preg   = '0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [6:0] p1, input logic r1, input logic [6:0] p2,
                      input logic r2, input logic [3:0] tag);
    disp_valid    = 1'b1;
    disp_prs1     = p1;
    disp_prs1_rdy = r1;
    disp_prs2     = p2;
    disp_prs2_rdy = r2;
    disp_prd      = {3'b101, tag};
    disp_rob_tag  = tag;
    disp_payload  = 44'({$urandom(), $urandom()});
  endtask

  // One clock: check outputs at the falling edge, advance the model, step past the rising edge
  task automatic cycle();
    int        sel;
    bit        exp_dr;
    bit        exp_iv;
    bit        dfire;
    bit        ifire;
    bit        hit;
    rs_entry_t e;
    @(negedge clk);
    sel    = pick_oldest_ready();
    exp_dr = (q.size() < RS_DEPTH) && !flush;
    exp_iv = (sel >= 0) && !flush;
    chk("disp_ready", 64'(disp_ready), 64'(exp_dr));
    chk("issue_valid", 64'(issue_valid), 64'(exp_iv));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (exp_iv) begin
      chk("issue_rob_tag", 64'(issue_rob_tag), 64'(q[sel].rob_tag));
      chk("issue_prs1", 64'(issue_prs1), 64'(q[sel].prs1));
      chk("issue_prs2", 64'(issue_prs2), 64'(q[sel].prs2));
      chk("issue_prd", 64'(issue_prd), 64'(q[sel].prd));
      chk("issue_payload", 64'(issue_payload), 64'(q[sel].payload));
    end
    if (issue_valid && issue_ready) dut_issued.push_back(issue_rob_tag);
    dfire = disp_valid && exp_dr;
    ifire = exp_iv && issue_ready;
    hit   = cdb_valid && (cdb_preg != 0);
    if (flush) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        if (hit && q[i].prs1 == cdb_preg) q[i].rdy1 = 1'b1;
        if (hit && q[i].prs2 == cdb_preg) q[i].rdy2 = 1'b1;
      end
      if (ifire) q.delete(sel);
      if (dfire) begin
        e.valid   = 1'b1;
        e.rdy1    = disp_prs1_rdy || (hit && cdb_preg == disp_prs1);
        e.rdy2    = disp_prs2_rdy || (hit && cdb_preg == disp_prs2);
        e.prs1    = disp_prs1;
        e.prs2    = disp_prs2;
        e.prd     = disp_prd;
        e.rob_tag = disp_rob_tag;
        e.payload = disp_payload;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    issue_ready = 1'b0;
    disp_prs1 = '0; disp_prs1_rdy = 1'b0; disp_prs2 = '0; disp_prs2_rdy = 1'b0;
    disp_prd = '0; disp_rob_tag = '0; disp_payload = '0;
    idle();
    #1;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_rob_tag", 64'(issue_rob_tag), 64'd0);
    chk("rst_issue_payload", 64'(issue_payload), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ready dispatch issues the next cycle
    issue_ready = 1'b1;
    disp(7'd5, 1'b1, 7'd6, 1'b1, 4'd3);
    cycle();
    idle();
    #1;
    chk("ready_issue_valid", 64'(issue_valid), 64'd1);
    chk("ready_issue_tag", 64'(issue_rob_tag), 64'd3);
    chk("ready_occ_1", 64'(occupancy), 64'd1);
    cycle();
    chk("ready_occ_0", 64'(occupancy), 64'd0);

    // Wakeup ordering: B issues in the broadcast cycle, A one cycle later
    dut_issued.delete();
    disp(7'd9, 1'b0, 7'd1, 1'b1, 4'd4);
    cycle();
    disp(7'd10, 1'b1, 7'd11, 1'b1, 4'd5);
    cycle();
    idle();
    cdb_valid = 1'b1;
    cdb_preg  = 7'd9;
    cycle();
    idle();
    cycle();
    cycle();
    chk("wake_count", 64'(dut_issued.size()), 64'd2);
    if (dut_issued.size() == 2) begin
      chk("wake_first", 64'(dut_issued[0]), 64'd5);
      chk("wake_second", 64'(dut_issued[1]), 64'd4);
    end

    // Dispatch-time bypass from a same-cycle broadcast
    disp(7'd12, 1'b0, 7'd13, 1'b1, 4'd6);
    cdb_valid = 1'b1;
    cdb_preg  = 7'd12;
    cycle();
    idle();
    #1;
    chk("bypass_issue_valid", 64'(issue_valid), 64'd1);
    chk("bypass_issue_tag", 64'(issue_rob_tag), 64'd6);
    cycle();

    // Fill under backpressure, then drain in age order
    issue_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      disp(7'(20 + t), 1'b1, 7'(40 + t), 1'b1, 4'(t));
      cycle();
    end
    disp(7'd30, 1'b1, 7'd31, 1'b1, 4'd8);
    repeat (3) cycle();
    idle();
    #1;
    chk("full_occ", 64'(occupancy), 64'd8);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    chk("full_hold_tag", 64'(issue_rob_tag), 64'd0);
    dut_issued.delete();
    issue_ready = 1'b1;
    cycle();
    chk("full_ready_after_fire", 64'(disp_ready), 64'd1);
    chk("full_occ_after_fire", 64'(occupancy), 64'd7);
    repeat (7) cycle();
    chk("drain_count", 64'(dut_issued.size()), 64'd8);
    for (int k = 0; k < dut_issued.size(); k++) chk("drain_order", 64'(dut_issued[k]), 64'(k));

    // Flush with a same-cycle dispatch
    issue_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      disp(7'(50 + t), 1'b1, 7'(60 + t), 1'b1, 4'(t));
      cycle();
    end
    disp(7'd70, 1'b1, 7'd71, 1'b1, 4'd9);
    flush = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("flush_disp_ready", 64'(disp_ready), 64'd0);
    chk("flush_issue_valid", 64'(issue_valid), 64'd0);
    cycle();
    idle();
    #1;
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_dropped", 64'(issue_valid), 64'd0);

    // Broadcast on preg 0 never wakes anything
    disp(7'd0, 1'b0, 7'd1, 1'b1, 4'd9);
    cycle();
    idle();
    cdb_valid = 1'b1;
    cdb_preg  = 7'd0;
    cycle();
    idle();
    cycle();
    chk("preg0_issue_valid", 64'(issue_valid), 64'd0);
    chk("preg0_occ", 64'(occupancy), 64'd1);
    flush = 1'b1;
    cycle();
    idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      disp_valid    = ($urandom_range(0, 3) != 0);
      disp_prs1     = 7'($urandom_range(0, 15));
      disp_prs1_rdy = ($urandom_range(0, 2) == 0);
      disp_prs2     = 7'($urandom_range(0, 15));
      disp_prs2_rdy = ($urandom_range(0, 2) == 0);
      disp_prd      = 7'($urandom_range(0, 127));
      disp_rob_tag  = 4'($urandom_range(0, 15));
      disp_payload  = 44'({$urandom(), $urandom()});
      cdb_valid     = 1'($urandom_range(0, 1));
      cdb_preg      = 7'($urandom_range(0, 15));
      issue_ready   = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle();

    // Asynchronous reset mid-stream
    issue_ready = 1'b0;
    flush = 1'b1;
    cycle();
    idle();
    for (int t = 0; t < 3; t++) begin
      disp(7'(80 + t), 1'b1, 7'(90 + t), 1'b1, 4'(t + 1));
      cycle();
    end
    idle();
    chk("pre_reset_occ", 64'(occupancy), 64'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("async_rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("async_rst_issue_tag", 64'(issue_rob_tag), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue_ready = 1'b1;
    disp(7'd100, 1'b1, 7'd101, 1'b1, 4'd12);
    cycle();
    idle();
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Reservation-station scheduler between rename/dispatch and the execution units.
- Buffers renamed micro-ops and tracks source-operand readiness through CDB wakeup broadcasts.
- Each cycle it selects the oldest micro-op whose operands are both ready and issues it over a valid/ready handshake.
- One instance per FU class (ALU, branch, LSU); a mispredict flush clears every entry.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PREG_W, 7, physical register index width.
- ROB_W, 4, ROB tag width.
- PAYLOAD_W, 44, opaque payload carried through unchanged: {pc[8:0], immediate[31:0], ALUOp[1:0], ALUsrc}.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- flush  in  1  branch mispredict; clears all entries.
- disp_valid  in  1  dispatch micro-op valid.
- disp_ready  out  1  scheduler can accept a dispatch this cycle.
- disp_prs1  in  PREG_W  physical source 1.
- disp_prs1_rdy  in  1  source 1 already ready at dispatch.
- disp_prs2  in  PREG_W  physical source 2.
- disp_prs2_rdy  in  1  source 2 already ready at dispatch.
- disp_prd  in  PREG_W  physical destination.
- disp_rob_tag  in  ROB_W  ROB tag.
- disp_payload  in  PAYLOAD_W  opaque payload.
- cdb_valid  in  1  wakeup broadcast valid.
- cdb_preg  in  PREG_W  physical register being written.
- issue_valid  out  1  issue candidate present.
- issue_ready  in  1  FU accepts the candidate.
- issue_prs1  out  PREG_W  source 1 of the issued micro-op.
- issue_prs2  out  PREG_W  source 2 of the issued micro-op.
- issue_prd  out  PREG_W  destination of the issued micro-op.
- issue_rob_tag  out  ROB_W  ROB tag of the issued micro-op.
- issue_payload  out  PAYLOAD_W  payload of the issued micro-op.
- occupancy  out  $clog2(DEPTH)+1  count of valid entries.

Behaviour:
- Reset (asynchronous, active-high):
  - All entry valid bits, ready bits and the age matrix clear.
  - occupancy=0, disp_ready=1, issue_valid=0; issue data outputs are 0.
- Entry state: valid, rdy1, rdy2, prs1, prs2, prd, rob_tag, payload.
- Age ordering uses a DEPTH x DEPTH age matrix. Bit age[i][j]=1 means entry i is older than entry j.
  - On allocating entry k: set age[j][k]=1 for every valid j, and clear row k.
- Dispatch:
  - disp_ready = (occupancy < DEPTH) && !flush.
  - disp_ready is conservative: a same-cycle issue does not free a slot for a same-cycle dispatch.
  - On disp_valid && disp_ready, the lowest-index free entry is written at the clock edge.
- Dispatch-time wakeup bypass: rdyN = disp_prsN_rdy || (cdb_valid && cdb_preg==disp_prsN && cdb_preg!=0).
- Wakeup:
  - Each cycle, every valid entry with rdyN=0 and prsN==cdb_preg (cdb_valid=1, cdb_preg!=0) sets rdyN at the edge.
  - A broadcast on preg 0 is ignored.
- Select (combinational from registered state only):
  - Candidate set = valid && rdy1 && rdy2.
  - Chosen entry = the candidate that no other candidate is older than.
  - issue_valid = |candidates && !flush; issue_* show the chosen entry's fields.
  - Wakeup-to-issue latency is 1 cycle: a micro-op woken at edge N can issue in cycle N+1, never in the same cycle as its broadcast.
  - Dispatch-to-issue latency is at least 1 cycle; there is no dispatch bypass to issue.
- Issue handshake:
  - On issue_valid && issue_ready, the chosen entry's valid bit clears at the edge.
  - With issue_ready=0, the same entry stays selected unless an older entry becomes ready. The FU samples only on fire.
- Occupancy counter:
  - +1 on dispatch fire, -1 on issue fire.
  - Simultaneous dispatch and issue fires leave it unchanged.
  - It never exceeds DEPTH and never underflows.
- Flush:
  - At the edge, all valid bits clear and occupancy goes to 0.
  - Dispatch and issue are both blocked in the flush cycle: disp_ready=0, issue_valid=0.
  - Flush has priority over wakeup, dispatch and issue.
- Full: disp_ready=0 until an issue fire has taken effect, i.e. one cycle after the issue fire.
- Empty: issue_valid=0; a CDB broadcast has no effect.
- Reset asserted mid-operation: state clears immediately, without waiting for a clock edge.

Decomposition:
- Shared package: typedef of the entry record (rs_entry_t) and the FU-type encoding constants (FU_ALU=2'b00, FU_BR=2'b01, FU_LSU=2'b10).
- Package width constants PREG_W=7, ROB_W=4 match the rename stage.
- One natural sub-module: rs_age_select. It takes the candidate vector and the age matrix and returns a one-hot grant plus index. It is purely combinational, so it can be verified standalone.

Test Plan:
- Ready dispatch: dispatch prs1=5 and prs2=6, both rdy=1, rob_tag=3, issue_ready=1 -> issue_valid=1 the next cycle with rob_tag=3; occupancy goes 1 then 0.
- Wakeup ordering: dispatch A (prs1=9 not ready), then B (ready); CDB preg=9 in the cycle B is written -> B issues first, A issues the following cycle; A never issues in the broadcast cycle.
- Dispatch bypass: dispatch prs1=12 with rdy=0 while cdb_valid=1, cdb_preg=12 -> entry captured ready; issues one cycle later.
- Full, backpressure and age order: fill 8 ready entries with rob_tags 0..7 and hold issue_ready=0 -> disp_ready=0, occupancy=8, issue_rob_tag stays 0. Release issue_ready -> tags issue in order 0..7; disp_ready=1 one cycle after the first fire.
- Flush: 5 entries valid plus a same-cycle disp_valid with flush=1 -> disp_ready=0, issue_valid=0; the next cycle occupancy=0 and the dispatched op is dropped.
- Preg 0 and reset: CDB preg=0 with an entry waiting on prs1=0 and rdy1=0 -> entry stays not ready. Assert reset mid-stream -> occupancy=0 and issue_valid=0 without waiting for a clock edge.
